uart_rx_sequencer: RTL
======================

// Module: uart_rx_sequencer
// PURPOSE
// - Frame-level controller for the UART receive path: 16x-oversampled tick generation, start-bit
//   qualification, mid-bit sampling, bit counting, parity/stop checking and FIFO store handshake.
// - Sits between the synchronised rx pin and the RX FIFO; drives the shift datapath via shift_en/sample_bit.
// - Owns all sequencing; the datapath only shifts when told.
// PARAMETERS
// - DATA_BITS  8   data bits per frame (5..8), LSB first on the line
// - OSR        16  oversample ticks per bit (even, >=4)
// - DIV_W      12  width of baud_divisor
// PORTS
// - clk            in   1          system clock; single clock domain
// - reset          in   1          synchronous, active-low reset
// - baud_divisor   in   DIV_W      clk cycles per oversample tick minus 1 (0 => tick every clk)
// - parity_en      in   1          1: parity bit follows data
// - parity_odd     in   1          1: odd parity, 0: even (ignored if !parity_en)
// - two_stop_bits  in   1          1: two stop bits checked
// - rx_in          in   1          raw line, idle high; 2-flop synchronised internally
// - fifo_full      in   1          RX FIFO cannot accept a write this cycle
// - shift_en       out  1          1-cycle pulse: datapath shifts in sample_bit
// - sample_bit     out  1          mid-bit sampled line value, valid with shift_en
// - frame_data     out  DATA_BITS  assembled data, stable while store_en high
// - store_en       out  1          1-cycle FIFO write strobe
// - rx_busy        out  1          high in any state except IDLE
// - parity_error   out  1          1-cycle pulse at frame end
// - stop_error     out  1          1-cycle pulse at frame end (any checked stop bit sampled 0)
// - break_detect   out  1          1-cycle pulse: all data bits 0 and first stop bit 0
// - overrun        out  1          1-cycle pulse: good frame dropped because fifo_full
// BEHAVIOUR
// - Reset (reset==0 at posedge): state IDLE, all counters 0, sync flops 1, every output 0.
//   Reset mid-frame aborts the frame with no store and no error pulses.
// - Tick: down-counter loaded with baud_divisor; tick when it reaches 0, then reloads.
//   Counter and oversample count are cleared on IDLE->START.
// - Config (baud_divisor, parity_en, parity_odd, two_stop_bits) is latched on IDLE->START;
//   changes mid-frame have no effect.
// - FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
//   IDLE:   falling edge on the synchronised line (prev 1, now 0) -> START. A line held low does not retrigger.
//   START:  on the (OSR/2)th tick, sample the line. 0 -> DATA with bit count cleared; 1 -> IDLE (false start, no pulses).
//   DATA:   every OSR ticks, sample and pulse shift_en. After DATA_BITS samples -> PARITY if parity_en, else STOP1.
//   PARITY: sample once after OSR ticks; parity is computed over the data bits plus the parity bit -> STOP1.
//   STOP1:  sample after OSR ticks -> STOP2 if two_stop_bits, else DONE.
//   STOP2:  sample after OSR ticks -> DONE.
//   DONE:   lasts exactly 1 cycle, then -> IDLE; outputs below are evaluated in this cycle.
// - DONE outputs:
//   - Any error: parity_error and/or stop_error pulse; store_en stays 0.
//   - No error and !fifo_full: store_en=1.
//   - No error and fifo_full: overrun=1, frame dropped.
//   - break_detect may pulse together with stop_error.
// - Latency: store_en rises 1 clk after the tick that samples the last stop bit.
// - A new falling edge is honoured in the cycle after DONE; back-to-back frames with one stop bit must not be lost.
// - frame_data holds its value until the next DATA entry.
// TESTING
// - div=3 (4 clk/tick, 64 clk/bit), 8N1, send 0xA5 -> exactly 8 shift_en; one store_en with frame_data=0xA5
//   at 1 clk after the stop sample; no error pulses.
// - rx_in low for 20 clk then high (shorter than the 32-clk start qualify) -> rx_busy returns to 0; no store_en, no errors.
// - parity_en=1, parity_odd=0, send 0x03 with parity bit 1 -> parity_error pulse; store_en stays 0.
// - two_stop_bits=1, second stop bit driven 0 -> stop_error pulse; no store.
//   Same frame with two_stop_bits=0 -> stored normally.
// - fifo_full=1, valid frame 0x5A -> overrun pulse; store_en stays 0.
//   Line held low for 2 frame-times -> break_detect + stop_error once, no retrigger until line goes high.
// - reset=0 for 1 clk mid-DATA -> all outputs 0 next cycle, IDLE.
//   A subsequent clean 0x3C frame is stored correctly.

Source files
------------

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: frame-level UART receive sequencer with oversampled mid-bit sampling and FIFO store handshake
module uart_rx_sequencer #(
    parameter int DATA_BITS = 8,
    parameter int OSR       = 16,
    parameter int DIV_W     = 12
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [DIV_W-1:0]     baud_divisor_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 two_stop_bits_i,
    input  logic                 rx_in_i,
    input  logic                 fifo_full_i,
    output logic                 shift_en_o,
    output logic                 sample_bit_o,
    output logic [DATA_BITS-1:0] frame_data_o,
    output logic                 store_en_o,
    output logic                 rx_busy_o,
    output logic                 parity_error_o,
    output logic                 stop_error_o,
    output logic                 break_detect_o,
    output logic                 overrun_o
);
    localparam int OSW = $clog2(OSR);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [OSW-1:0] OS_HALF  = OSW'(OSR / 2 - 1);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OSR - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, DONE} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q, prev_q;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d, div_q, div_d;
    logic [OSW-1:0]       os_cnt_q, os_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] frame_q, frame_d;
    logic                 par_q, par_d, stop_err_q, stop_err_d, brk_q, brk_d;
    logic                 par_en_q, par_en_d, par_odd_q, par_odd_d, two_stop_q, two_stop_d;
    logic                 tick, bit_done, err;

    assign tick         = (state_q != IDLE) && (div_cnt_q == '0);
    assign bit_done     = tick && (os_cnt_q == OS_LAST);
    assign rx_busy_o    = state_q != IDLE;
    assign frame_data_o = frame_q;
    assign sample_bit_o = shift_en_o & sync2_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            div_cnt_q  <= '0;
            div_q      <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            par_q      <= 1'b0;
            stop_err_q <= 1'b0;
            brk_q      <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= rx_in_i;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            div_cnt_q  <= div_cnt_d;
            div_q      <= div_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            par_q      <= par_d;
            stop_err_q <= stop_err_d;
            brk_q      <= brk_d;
            par_en_q   <= par_en_d;
            par_odd_q  <= par_odd_d;
            two_stop_q <= two_stop_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        div_cnt_d      = div_cnt_q;
        div_d          = div_q;
        os_cnt_d       = os_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        frame_d        = frame_q;
        par_d          = par_q;
        stop_err_d     = stop_err_q;
        brk_d          = brk_q;
        par_en_d       = par_en_q;
        par_odd_d      = par_odd_q;
        two_stop_d     = two_stop_q;
        shift_en_o     = 1'b0;
        store_en_o     = 1'b0;
        parity_error_o = 1'b0;
        stop_error_o   = 1'b0;
        break_detect_o = 1'b0;
        overrun_o      = 1'b0;
        err            = 1'b0;
        if (tick) begin
            div_cnt_d = div_q;
            os_cnt_d  = os_cnt_q + 1'b1;
        end else if (state_q != IDLE) begin
            div_cnt_d = div_cnt_q - 1'b1;
        end
        unique case (state_q)
            IDLE: if (prev_q && !sync2_q) begin
                state_d    = START;
                div_cnt_d  = '0;
                os_cnt_d   = '0;
                div_d      = baud_divisor_i;
                par_en_d   = parity_en_i;
                par_odd_d  = parity_odd_i;
                two_stop_d = two_stop_bits_i;
            end
            START: if (tick && os_cnt_q == OS_HALF) begin
                state_d   = sync2_q ? IDLE : DATA;
                os_cnt_d  = '0;
                bit_cnt_d = '0;
                par_d     = 1'b0;
            end
            DATA: if (bit_done) begin
                shift_en_o = 1'b1;
                frame_d    = {sync2_q, frame_q[DATA_BITS-1:1]};
                par_d      = par_q ^ sync2_q;
                bit_cnt_d  = bit_cnt_q + 1'b1;
                os_cnt_d   = '0;
                state_d    = (bit_cnt_q != BIT_LAST) ? DATA : par_en_q ? PARITY : STOP1;
            end
            PARITY: if (bit_done) begin
                par_d    = par_q ^ sync2_q;
                os_cnt_d = '0;
                state_d  = STOP1;
            end
            STOP1: if (bit_done) begin
                stop_err_d = !sync2_q;
                brk_d      = !sync2_q && (frame_q == '0);
                os_cnt_d   = '0;
                state_d    = two_stop_q ? STOP2 : DONE;
            end
            STOP2: if (bit_done) begin
                stop_err_d = stop_err_q | !sync2_q;
                os_cnt_d   = '0;
                state_d    = DONE;
            end
            DONE: begin
                // par_q holds the XOR of data plus parity bit; it must equal the odd flag
                parity_error_o = par_en_q && (par_q != par_odd_q);
                stop_error_o   = stop_err_q;
                break_detect_o = brk_q;
                err            = parity_error_o || stop_err_q;
                store_en_o     = !err && !fifo_full_i;
                overrun_o      = !err && fifo_full_i;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
